// File: rtl/tour_pos_tracker_pkg.sv
// Shared types and constants for the knight-tour position tracker,
// the tour command stage and the chip-level bench.
package tour_pkg;

    localparam int DEF_BOARD_DIM = 5;
    localparam int DEF_NUM_MOVES = DEF_BOARD_DIM * DEF_BOARD_DIM - 1;
    localparam int SQUARES       = DEF_BOARD_DIM * DEF_BOARD_DIM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OFF_BOARD = 2'b01,
        ERR_REVISIT   = 2'b10,
        ERR_BAD_ENC   = 2'b11
    } err_code_t;

    // Knight offsets indexed by the one-hot move bit.
    localparam logic signed [2:0] MOVE_DX [8] = '{
        3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1, 3'sd2
    };
    localparam logic signed [2:0] MOVE_DY [8] = '{
        3'sd1, 3'sd2, 3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1
    };

endpackage

// File: rtl/tour_pos_tracker_if.sv
// Command and status bundle between the tour command stage and the tracker.
interface tour_pos_if;
    import tour_pkg::*;

    logic               start_tour;
    logic [2:0]         x_start;
    logic [2:0]         y_start;
    logic               mv_vld;
    logic [7:0]         move;
    logic [2:0]         xx;
    logic [2:0]         yy;
    logic [4:0]         mv_cnt;
    logic [SQUARES-1:0] visited;
    logic               pos_vld;
    logic               tour_done;
    logic               err;
    logic [1:0]         err_code;

    modport master (
        output start_tour, x_start, y_start, mv_vld, move,
        input  xx, yy, mv_cnt, visited, pos_vld, tour_done, err, err_code
    );

    modport slave (
        input  start_tour, x_start, y_start, mv_vld, move,
        output xx, yy, mv_cnt, visited, pos_vld, tour_done, err, err_code
    );

endinterface

// File: rtl/tour_pos_tracker_knight_move_dec.sv
// One-hot knight move decoder: offset lookup plus encoding check.
module knight_move_dec
    import tour_pkg::*;
(
    input  logic [7:0]        move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy,
    output logic              onehot_ok
);

    assign onehot_ok = $onehot(move);

    // Offsets are only meaningful when onehot_ok is set.
    always_comb begin
        dx = '0;
        dy = '0;
        for (int i = 0; i < 8; i++) begin
            if (move[i]) begin
                dx = MOVE_DX[i];
                dy = MOVE_DY[i];
            end
        end
    end

endmodule

// File: rtl/tour_pos_tracker.sv
// Knight position tracker: current square, visited map, move count and
// error/completion status, one-cycle latency on start_tour and mv_vld.
module tour_pos_tracker
    import tour_pkg::*;
#(
    parameter int BOARD_DIM = DEF_BOARD_DIM,
    parameter int NUM_MOVES = DEF_NUM_MOVES
) (
    input  logic     clk,
    input  logic     rst_n,
    tour_pos_if.slave bus
);

    localparam logic [2:0] MAX_COORD = 3'(BOARD_DIM - 1);
    localparam logic [SQUARES-1:0] ONE_SQ = {{(SQUARES-1){1'b0}}, 1'b1};

    state_t             state_q, state_n;
    logic [2:0]         xx_q, yy_q, xx_n, yy_n;
    logic [4:0]         cnt_q, cnt_n;
    logic [SQUARES-1:0] vis_q, vis_n;
    err_code_t          code_q, code_n;
    logic               pos_vld_q, done_q, err_q;

    logic signed [2:0]  dx, dy;
    logic               onehot_ok;
    logic [3:0]         nx, ny;
    logic               off_board, revisit, start_bad;
    logic [5:0]         tgt_idx, start_idx;
    logic [SQUARES-1:0] tgt_mask, start_mask;

    knight_move_dec u_dec (
        .move      (bus.move),
        .dx        (dx),
        .dy        (dy),
        .onehot_ok (onehot_ok)
    );

    // 4-bit two's complement target; bit 3 set means a negative coordinate.
    assign nx = {1'b0, xx_q} + {dx[2], dx};
    assign ny = {1'b0, yy_q} + {dy[2], dy};

    assign off_board  = nx[3] | ny[3] | (nx[2:0] > MAX_COORD) | (ny[2:0] > MAX_COORD);
    assign tgt_idx    = 6'(ny[2:0]) * 6'(BOARD_DIM) + 6'(nx[2:0]);
    assign tgt_mask   = ONE_SQ << tgt_idx;
    assign revisit    = |(vis_q & tgt_mask);

    assign start_bad  = (bus.x_start > MAX_COORD) | (bus.y_start > MAX_COORD);
    assign start_idx  = 6'(bus.y_start) * 6'(BOARD_DIM) + 6'(bus.x_start);
    assign start_mask = ONE_SQ << start_idx;

    // Next-state and datapath update; start_tour overrides any move.
    always_comb begin
        state_n = state_q;
        xx_n    = xx_q;
        yy_n    = yy_q;
        cnt_n   = cnt_q;
        vis_n   = vis_q;
        code_n  = code_q;
        if (bus.start_tour) begin
            if (start_bad) begin
                state_n = ST_ERR;
                code_n  = ERR_OFF_BOARD;
                xx_n    = '0;
                yy_n    = '0;
                cnt_n   = '0;
                vis_n   = '0;
            end else begin
                state_n = ST_TRACK;
                code_n  = ERR_NONE;
                xx_n    = bus.x_start;
                yy_n    = bus.y_start;
                cnt_n   = '0;
                vis_n   = start_mask;
            end
        end else if (state_q == ST_TRACK && bus.mv_vld) begin
            if (!onehot_ok) begin
                state_n = ST_ERR;
                code_n  = ERR_BAD_ENC;
            end else if (off_board) begin
                state_n = ST_ERR;
                code_n  = ERR_OFF_BOARD;
            end else if (revisit) begin
                state_n = ST_ERR;
                code_n  = ERR_REVISIT;
            end else begin
                xx_n  = nx[2:0];
                yy_n  = ny[2:0];
                vis_n = vis_q | tgt_mask;
                if (cnt_q != 5'(NUM_MOVES))
                    cnt_n = cnt_q + 5'd1;
                if (cnt_q + 5'd1 >= 5'(NUM_MOVES))
                    state_n = ST_DONE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_n;
    end

    // Position, history and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xx_q      <= '0;
            yy_q      <= '0;
            cnt_q     <= '0;
            vis_q     <= '0;
            code_q    <= ERR_NONE;
            pos_vld_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            xx_q      <= xx_n;
            yy_q      <= yy_n;
            cnt_q     <= cnt_n;
            vis_q     <= vis_n;
            code_q    <= code_n;
            pos_vld_q <= (state_n == ST_TRACK) || (state_n == ST_DONE);
            done_q    <= (state_n == ST_DONE);
            err_q     <= (state_n == ST_ERR);
        end
    end

    assign bus.xx        = xx_q;
    assign bus.yy        = yy_q;
    assign bus.mv_cnt    = cnt_q;
    assign bus.visited   = vis_q;
    assign bus.pos_vld   = pos_vld_q;
    assign bus.tour_done = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_tour_pos_tracker.sv
// Bench for tour_pos_tracker: directed tour scenarios plus randomized walks
// checked against a square-level reference model.
module tb_tour_pos_tracker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tour_pos_if bus ();

    tour_pos_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Knight offsets by move bit, written out independently of the RTL.
    int ref_dx [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int ref_dy [8] = '{1, 2, 2, 1, -1, -2, -2, -1};

    // Open 5x5 tour from (0,0), listed as (x,y) per square visited.
    int tour_x [25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};
    int tour_y [25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: 0 idle, 1 tracking, 2 done, 3 error.
    int m_mode, m_x, m_y, m_cnt, m_code;
    bit m_vis [25];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0; m_code = 0;
        foreach (m_vis[i]) m_vis[i] = 1'b0;
    endtask

    function automatic int move_bit(input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return -1;
    endfunction

    function automatic bit is_legal(input int k);
        int tx, ty;
        tx = m_x + ref_dx[k];
        ty = m_y + ref_dy[k];
        if (tx < 0 || tx > 4 || ty < 0 || ty > 4) return 1'b0;
        return !m_vis[ty*5 + tx];
    endfunction

    task automatic model_step();
        int k, tx, ty;
        if (bus.start_tour) begin
            model_reset();
            if (bus.x_start > 4 || bus.y_start > 4) begin
                m_mode = 3; m_code = 1;
            end else begin
                m_mode = 1;
                m_x = int'(bus.x_start);
                m_y = int'(bus.y_start);
                m_vis[m_y*5 + m_x] = 1'b1;
            end
        end else if (m_mode == 1 && bus.mv_vld) begin
            if ($countones(bus.move) != 1) begin
                m_mode = 3; m_code = 3;
            end else begin
                k  = move_bit(bus.move);
                tx = m_x + ref_dx[k];
                ty = m_y + ref_dy[k];
                if (tx < 0 || tx > 4 || ty < 0 || ty > 4) begin
                    m_mode = 3; m_code = 1;
                end else if (m_vis[ty*5 + tx]) begin
                    m_mode = 3; m_code = 2;
                end else begin
                    m_x = tx; m_y = ty;
                    m_vis[ty*5 + tx] = 1'b1;
                    m_cnt++;
                    if (m_cnt == 24) m_mode = 2;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [24:0] v;
        foreach (m_vis[i]) v[i] = m_vis[i];
        chk({tag, ".xx"},        32'(bus.xx),        32'(m_x));
        chk({tag, ".yy"},        32'(bus.yy),        32'(m_y));
        chk({tag, ".mv_cnt"},    32'(bus.mv_cnt),    32'(m_cnt));
        chk({tag, ".visited"},   32'(bus.visited),   32'(v));
        chk({tag, ".pos_vld"},   32'(bus.pos_vld),   32'(m_mode == 1 || m_mode == 2));
        chk({tag, ".tour_done"}, 32'(bus.tour_done), 32'(m_mode == 2));
        chk({tag, ".err"},       32'(bus.err),       32'(m_mode == 3));
        chk({tag, ".err_code"},  32'(bus.err_code),  32'(m_code));
    endtask

    task automatic drive_idle();
        bus.start_tour = 1'b0;
        bus.x_start    = '0;
        bus.y_start    = '0;
        bus.mv_vld     = 1'b0;
        bus.move       = '0;
    endtask

    // One clock: model follows the inputs in place at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        drive_idle();
    endtask

    task automatic do_start(input int x, input int y, input string tag);
        bus.start_tour = 1'b1;
        bus.x_start    = 3'(x);
        bus.y_start    = 3'(y);
        step(tag);
    endtask

    task automatic do_move(input logic [7:0] m, input string tag);
        bus.mv_vld = 1'b1;
        bus.move   = m;
        step(tag);
    endtask

    function automatic logic [7:0] tour_move(input int i);
        int ddx, ddy;
        logic [7:0] m;
        ddx = tour_x[i+1] - tour_x[i];
        ddy = tour_y[i+1] - tour_y[i];
        m = '0;
        for (int k = 0; k < 8; k++)
            if (ref_dx[k] == ddx && ref_dy[k] == ddy) m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        int r, k0;
        logic [7:0] m;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Off-board second move.
        do_start(2, 2, "ob_start");
        do_move(8'h01, "ob_m1");
        do_move(8'h04, "ob_m2");
        chk("ob.err",      32'(bus.err),      32'd1);
        chk("ob.err_code", 32'(bus.err_code), 32'd1);
        chk("ob.xy",       32'({bus.xx, bus.yy}), 32'({3'd4, 3'd3}));
        chk("ob.mv_cnt",   32'(bus.mv_cnt),   32'd1);
        do_move(8'h02, "ob_ignored");

        // Return to the start square.
        do_start(2, 2, "rv_start");
        do_move(8'h01, "rv_m1");
        do_move(8'h10, "rv_m2");
        chk("rv.err_code", 32'(bus.err_code), 32'd2);
        chk("rv.mv_cnt",   32'(bus.mv_cnt),   32'd1);
        chk("rv.visited",  32'(bus.visited),  32'((1 << 12) | (1 << 19)));

        // Two bits set.
        do_start(0, 0, "be_start");
        do_move(8'h03, "be_m1");
        chk("be.err_code", 32'(bus.err_code), 32'd3);
        chk("be.xy",       32'({bus.xx, bus.yy}), 32'd0);
        chk("be.mv_cnt",   32'(bus.mv_cnt),   32'd0);

        // Full tour, back-to-back moves.
        do_start(0, 0, "tour_start");
        for (int i = 0; i < 24; i++) begin
            chk("tour.not_done_early", 32'(bus.tour_done), 32'd0);
            do_move(tour_move(i), "tour_mv");
        end
        chk("tour.done",    32'(bus.tour_done), 32'd1);
        chk("tour.mv_cnt",  32'(bus.mv_cnt),    32'd24);
        chk("tour.visited", 32'(bus.visited),   32'h1FFFFFF);
        chk("tour.err",     32'(bus.err),       32'd0);
        do_move(8'h01, "tour_extra");
        chk("tour.extra_cnt", 32'(bus.mv_cnt), 32'd24);

        // start_tour coincident with a move mid-tour.
        do_start(0, 0, "co_start");
        do_move(tour_move(0), "co_m1");
        do_move(tour_move(1), "co_m2");
        bus.mv_vld = 1'b1;
        bus.move   = tour_move(2);
        do_start(1, 3, "co_restart");
        chk("co.xy",      32'({bus.xx, bus.yy}), 32'({3'd1, 3'd3}));
        chk("co.mv_cnt",  32'(bus.mv_cnt),  32'd0);
        chk("co.visited", 32'(bus.visited), 32'(1 << 16));
        do_start(5, 0, "bad_start");
        chk("bs.err_code", 32'(bus.err_code), 32'd1);
        chk("bs.err",      32'(bus.err),      32'd1);

        // Asynchronous reset after move 10.
        do_start(0, 0, "rst_start");
        for (int i = 0; i < 10; i++) do_move(tour_move(i), "rst_mv");
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst.xx",       32'(bus.xx),        32'd0);
        chk("rst.mv_cnt",   32'(bus.mv_cnt),    32'd0);
        chk("rst.visited",  32'(bus.visited),   32'd0);
        chk("rst.pos_vld",  32'(bus.pos_vld),   32'd0);
        chk("rst.err_code", 32'(bus.err_code),  32'd0);
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        do_move(8'h01, "idle_mv1");
        do_move(8'h03, "idle_mv2");
        chk("idle.err", 32'(bus.err), 32'd0);
        do_start(2, 2, "post_rst_start");
        do_move(8'h01, "post_rst_mv");

        // Randomized walks.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) == 0)
                do_start(int'($urandom_range(5, 7)), int'($urandom_range(0, 7)), "rnd_start");
            else
                do_start(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), "rnd_start");
            for (int c = 0; c < 30; c++) begin
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    do_move(8'($urandom), "rnd_raw");
                end else if (r < 14) begin
                    step("rnd_idle");
                end else if (r < 17) begin
                    bus.mv_vld = 1'b1;
                    bus.move   = 8'($urandom);
                    do_start(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), "rnd_co");
                end else begin
                    m  = 8'(1 << $urandom_range(0, 7));
                    k0 = int'($urandom_range(0, 7));
                    if (r < 85) begin
                        for (int j = 0; j < 8; j++)
                            if (is_legal((k0 + j) % 8)) begin
                                m = 8'(1 << ((k0 + j) % 8));
                                break;
                            end
                    end
                    do_move(m, "rnd_mv");
                end
                if (m_mode >= 2 && $urandom_range(0, 3) == 0) break;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
